// File: rtl/bcd_display_scheduler_pkg.sv
// Shared definitions for the BCD display scheduler: source and FSM encodings,
// engine sizing and the round-robin successor helper.
package bcd_display_scheduler_pkg;

  localparam int unsigned IN_W        = 32;
  localparam int unsigned NDIG        = 10;
  localparam int unsigned NSRC        = 3;
  localparam logic [3:0]  BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    SRC_OUT = 2'd0,
    SRC_PC  = 2'd1,
    SRC_FP  = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic src_t next_src(input src_t s);
    case (s)
      SRC_OUT: return SRC_PC;
      SRC_PC:  return SRC_FP;
      default: return SRC_OUT;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_scheduler_dd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// accumulator left by one, pulling in the next binary MSB.
module bcd_dd_step #(
  parameter int unsigned NDIG = 10
) (
  input  logic [4*NDIG-1:0] acc,
  input  logic              bit_in,
  output logic [4*NDIG-1:0] acc_next
);

  logic [3:0] d;

  always_comb begin
    acc_next    = '0;
    acc_next[0] = bit_in;
    d           = '0;
    for (int unsigned i = 0; i < NDIG - 1; i++) begin
      d = acc[4*i +: 4];
      if (d >= 4'd5) d = d + 4'd3;
      acc_next[4*i+1 +: 4] = d;
    end
    // Top digit's carry-out is dropped: NDIG is sized so it never overflows.
    d = acc[4*(NDIG-1) +: 4];
    if (d >= 4'd5) d = d + 4'd3;
    acc_next[4*NDIG-3 +: 3] = d[2:0];
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Shared binary-to-BCD engine serving the OUT, PC and FP seven-segment displays
// through a round-robin arbiter and a 32-step double-dabble shifter.
module bcd_display_scheduler
  import bcd_display_scheduler_pkg::*;
#(
  parameter int unsigned IN_W = bcd_display_scheduler_pkg::IN_W,
  parameter int unsigned NDIG = bcd_display_scheduler_pkg::NDIG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            out_req,
  input  logic [IN_W-1:0] out_val,
  input  logic            pc_req,
  input  logic [9:0]      pc_val,
  input  logic            fp_req,
  input  logic [IN_W-1:0] fp_val,
  input  logic            halt,
  output logic [3:0]      out_d0,
  output logic [3:0]      out_d1,
  output logic [3:0]      out_d2,
  output logic [3:0]      out_d3,
  output logic [3:0]      pc_d0,
  output logic [3:0]      pc_d1,
  output logic [3:0]      fp_d0,
  output logic [3:0]      fp_d1,
  output logic            busy,
  output logic            done,
  output logic [1:0]      done_src
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  state_t            state, state_next;
  logic [NSRC-1:0]   pending;
  logic [IN_W-1:0]   val_q [NSRC];
  src_t              ptr, cur, grant_src, cand;
  logic              grant_any;
  logic [IN_W-1:0]   shreg;
  logic [4*NDIG-1:0] acc, acc_step;
  logic [CNT_W-1:0]  cnt;
  logic              load, shift_en, write_en;

  // Round-robin search starting at ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_src = ptr;
    cand      = ptr;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!grant_any && pending[cand]) begin
        grant_any = 1'b1;
        grant_src = cand;
      end
      cand = next_src(cand);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (grant_any) state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_W'(IN_W - 1)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = (state == ST_IDLE) && grant_any;
    shift_en = (state == ST_SHIFT);
    write_en = (state == ST_DONE);
    busy     = (state == ST_SHIFT) || (state == ST_DONE);
  end

  // Request capture; ordering makes a same-edge strobe win over the grant clear,
  // and halt win over everything for the PC slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      for (int unsigned i = 0; i < NSRC; i++) val_q[i] <= '0;
    end else begin
      if (load) pending[grant_src] <= 1'b0;
      if (out_req) begin
        pending[SRC_OUT] <= 1'b1;
        val_q[SRC_OUT]   <= out_val;
      end
      if (pc_req && !halt) begin
        pending[SRC_PC] <= 1'b1;
        val_q[SRC_PC]   <= IN_W'(pc_val);
      end
      if (fp_req) begin
        pending[SRC_FP] <= 1'b1;
        val_q[SRC_FP]   <= fp_val;
      end
      if (halt) pending[SRC_PC] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      cur   <= SRC_OUT;
      ptr   <= SRC_OUT;
    end else if (load) begin
      shreg <= val_q[grant_src];
      acc   <= '0;
      cnt   <= '0;
      cur   <= grant_src;
      ptr   <= next_src(grant_src);
    end else if (shift_en) begin
      acc   <= acc_step;
      shreg <= {shreg[IN_W-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
    end
  end

  bcd_dd_step #(.NDIG(NDIG)) u_step (
    .acc      (acc),
    .bit_in   (shreg[IN_W-1]),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_d0   <= '0;
      out_d1   <= '0;
      out_d2   <= '0;
      out_d3   <= '0;
      pc_d0    <= '0;
      pc_d1    <= '0;
      fp_d0    <= '0;
      fp_d1    <= '0;
      done     <= 1'b0;
      done_src <= '0;
    end else begin
      done <= write_en;
      if (write_en) begin
        done_src <= cur;
        case (cur)
          SRC_OUT: begin
            out_d0 <= acc[3:0];
            out_d1 <= acc[7:4];
            out_d2 <= acc[11:8];
            out_d3 <= acc[15:12];
          end
          SRC_PC: begin
            if (!halt) begin
              pc_d0 <= acc[3:0];
              pc_d1 <= acc[7:4];
            end
          end
          SRC_FP: begin
            fp_d0 <= acc[3:0];
            fp_d1 <= acc[7:4];
          end
          default: ;
        endcase
      end
      if (halt) begin
        pc_d0 <= BLANK_DIGIT;
        pc_d1 <= BLANK_DIGIT;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench for bcd_display_scheduler: expected digits are queued at
// strobe time from an arithmetic mod/div model and popped on each done pulse.
module tb_bcd_display_scheduler;

  logic        clk = 1'b0;
  logic        reset, out_req, pc_req, fp_req, halt;
  logic [31:0] out_val, fp_val;
  logic [9:0]  pc_val;
  logic [3:0]  out_d0, out_d1, out_d2, out_d3, pc_d0, pc_d1, fp_d0, fp_d1;
  logic        busy, done;
  logic [1:0]  done_src;

  int          vectors = 0;
  int          miscompares = 0;
  logic [17:0] sb[$];

  always #5 clk = ~clk;

  bcd_display_scheduler dut (
    .clk(clk), .reset(reset),
    .out_req(out_req), .out_val(out_val),
    .pc_req(pc_req), .pc_val(pc_val),
    .fp_req(fp_req), .fp_val(fp_val),
    .halt(halt),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
    .pc_d0(pc_d0), .pc_d1(pc_d1), .fp_d0(fp_d0), .fp_d1(fp_d1),
    .busy(busy), .done(done), .done_src(done_src)
  );

  function automatic logic [17:0] exp_out(input logic [31:0] v);
    logic [31:0] m;
    m = v % 32'd10000;
    return {2'd0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [17:0] exp_two(input logic [1:0] src, input logic [31:0] v);
    return {src, 8'h00, 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; out_req = 1'b0; pc_req = 1'b0; fp_req = 1'b0; halt = 1'b0;
    out_val = '0; pc_val = '0; fp_val = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic pulse_out(input logic [31:0] v);
    @(negedge clk); out_val = v; out_req = 1'b1;
    @(posedge clk); #1; out_req = 1'b0;
  endtask

  task automatic pulse_pc(input logic [9:0] v);
    @(negedge clk); pc_val = v; pc_req = 1'b1;
    @(posedge clk); #1; pc_req = 1'b0;
  endtask

  task automatic pulse_fp(input logic [31:0] v);
    @(negedge clk); fp_val = v; fp_req = 1'b1;
    @(posedge clk); #1; fp_req = 1'b0;
  endtask

  // Waits up to budget edges for done; returns the digits belonging to done_src.
  task automatic wait_done(input int budget, output bit seen, output int lat,
                           output logic [17:0] obs);
    seen = 1'b0; lat = 0; obs = '0;
    while (!seen && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
    case (done_src)
      2'd0:    obs = {done_src, out_d3, out_d2, out_d1, out_d0};
      2'd1:    obs = {done_src, 8'h00, pc_d1, pc_d0};
      default: obs = {done_src, 8'h00, fp_d1, fp_d0};
    endcase
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    vectors++;
    if ({out_d3, out_d2, out_d1, out_d0, pc_d1, pc_d0, fp_d1, fp_d0, busy, done, done_src} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got digits=%h busy=%b done=%b src=%0d want all zero",
               {out_d3, out_d2, out_d1, out_d0, pc_d1, pc_d0, fp_d1, fp_d0}, busy, done, done_src);
    end
  endtask

  task automatic test_basic();
    bit seen; int lat; logic [17:0] obs, e;
    do_reset();
    pulse_out(32'd1234);
    sb.push_back(exp_out(32'd1234));
    wait_done(40, seen, lat, obs);
    vectors++;
    if (!seen || lat !== 34) begin
      miscompares++;
      $display("FAIL basic_latency got seen=%0d lat=%0d want seen=1 lat=34", seen, lat);
    end
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL basic_digits got %h want %h", obs, e);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy_after got %b want 0", busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_width got done=%b want 0 on second cycle", done);
    end
  endtask

  task automatic test_max_values();
    bit seen; int lat; logic [17:0] obs, e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin pulse_out(32'hFFFF_FFFF); sb.push_back(exp_out(32'hFFFF_FFFF)); end
        1: begin pulse_fp(32'hFFFF_FFFF);  sb.push_back(exp_two(2'd2, 32'hFFFF_FFFF)); end
        default: begin pulse_pc(10'd1023); sb.push_back(exp_two(2'd1, 32'd1023)); end
      endcase
      wait_done(40, seen, lat, obs);
      e = sb.pop_front();
      vectors++;
      if (!seen || obs !== e) begin
        miscompares++;
        $display("FAIL max_values[%0d] got seen=%0d %h want %h", i, seen, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen; int lat; logic [17:0] obs, e;
    do_reset();
    @(negedge clk);
    out_val = 32'd5678; pc_val = 10'd987; fp_val = 32'd42;
    out_req = 1'b1; pc_req = 1'b1; fp_req = 1'b1;
    @(posedge clk); #1;
    out_req = 1'b0; pc_req = 1'b0; fp_req = 1'b0;
    sb.push_back(exp_out(32'd5678));
    sb.push_back(exp_two(2'd1, 32'd987));
    sb.push_back(exp_two(2'd2, 32'd42));
    for (int i = 0; i < 3; i++) begin
      wait_done(40, seen, lat, obs);
      e = sb.pop_front();
      vectors++;
      if (!seen || lat !== 34 || obs !== e) begin
        miscompares++;
        $display("FAIL b2b[%0d] got seen=%0d lat=%0d %h want lat=34 %h", i, seen, lat, obs, e);
      end
    end
  endtask

  task automatic test_overwrite();
    bit seen; int lat; logic [17:0] obs, e;
    do_reset();
    pulse_out(32'd1111);
    sb.push_back(exp_out(32'd1111));
    repeat (3) @(negedge clk);
    pulse_pc(10'd15);
    repeat (5) @(negedge clk);
    pulse_pc(10'd73);
    sb.push_back(exp_two(2'd1, 32'd73));
    for (int i = 0; i < 2; i++) begin
      wait_done(60, seen, lat, obs);
      e = sb.pop_front();
      vectors++;
      if (!seen || obs !== e) begin
        miscompares++;
        $display("FAIL overwrite[%0d] got seen=%0d %h want %h", i, seen, obs, e);
      end
    end
    wait_done(40, seen, lat, obs);
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL overwrite_single got extra done src=%0d want none", done_src);
    end
  endtask

  task automatic test_halt();
    bit seen; int lat; logic [17:0] obs, e;
    do_reset();
    pulse_pc(10'd56);
    sb.push_back({2'd1, 8'h00, 4'hF, 4'hF});
    repeat (5) @(negedge clk);
    halt = 1'b1;
    wait_done(40, seen, lat, obs);
    e = sb.pop_front();
    vectors++;
    if (!seen || obs !== e) begin
      miscompares++;
      $display("FAIL halt_discard got seen=%0d %h want %h", seen, obs, e);
    end
    @(negedge clk);
    halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({pc_d1, pc_d0} !== 8'hFF) begin
      miscompares++;
      $display("FAIL halt_hold got %h want ff", {pc_d1, pc_d0});
    end
    pulse_pc(10'd56);
    sb.push_back(exp_two(2'd1, 32'd56));
    wait_done(40, seen, lat, obs);
    e = sb.pop_front();
    vectors++;
    if (!seen || obs !== e) begin
      miscompares++;
      $display("FAIL halt_resume got seen=%0d %h want %h", seen, obs, e);
    end
  endtask

  task automatic test_reset_abort();
    bit seen; int lat; logic [17:0] obs, e;
    do_reset();
    pulse_out(32'd1234);
    sb.push_back(exp_out(32'd1234));
    wait_done(40, seen, lat, obs);
    e = sb.pop_front();
    vectors++;
    if (!seen || obs !== e) begin
      miscompares++;
      $display("FAIL abort_pre got seen=%0d %h want %h", seen, obs, e);
    end
    pulse_out(32'd9999);
    sb.push_back(exp_out(32'd9999));
    repeat (11) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy got %b want 1", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, out_d3, out_d2, out_d1, out_d0} !== '0) begin
      miscompares++;
      $display("FAIL abort_state got busy=%b done=%b out=%h want 0 0 0000",
               busy, done, {out_d3, out_d2, out_d1, out_d0});
    end
    @(negedge clk);
    reset = 1'b0;
    wait_done(40, seen, lat, obs);
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_no_done got done after reset want none");
    end
  endtask

  initial begin
    reset = 1'b1; out_req = 1'b0; pc_req = 1'b0; fp_req = 1'b0; halt = 1'b0;
    out_val = '0; pc_val = '0; fp_val = '0;
    test_reset();
    test_basic();
    test_max_values();
    test_back_to_back();
    test_overwrite();
    test_halt();
    test_reset_abort();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
